// File: rtl/matmul_seq.sv
// matmul_seq: sequences C = A x B for signed 8-bit square matrices (2x2..5x5)
// through one external inner-product unit, one result element per cycle.
module matmul_seq #(
    parameter int EW  = 8,
    parameter int DIM = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             size,
    input  logic [DIM*DIM*EW-1:0]  mat_a,
    input  logic [DIM*DIM*EW-1:0]  mat_b,
    output logic [DIM*EW-1:0]      lin,
    output logic [DIM*EW-1:0]      col,
    input  logic [EW-1:0]          ip_prod,
    input  logic                   ip_ovf,
    output logic [DIM*DIM*EW-1:0]  mat_c,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int MW = DIM*DIM*EW;
    localparam int VW = DIM*EW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [MW-1:0]   a_q;
    logic [MW-1:0]   b_q;
    logic [2:0]      n_q;
    logic [2:0]      i;
    logic [2:0]      j;

    logic [2:0]      n_start;
    logic            last_j;
    logic            last_elem;
    logic [2:0]      next_i;
    logic [2:0]      next_j;
    int              elem_idx;

    // Row r of matrix m, elements at positions k >= n forced to zero.
    function automatic logic [VW-1:0] row_of(input logic [MW-1:0] m,
                                             input logic [2:0] r,
                                             input logic [2:0] n);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < DIM; k++)
            for (int rr = 0; rr < DIM; rr++)
                if (rr == int'(r) && k < int'(n))
                    v[VW-1-EW*k -: EW] = m[MW-1-EW*(DIM*rr+k) -: EW];
        return v;
    endfunction

    // Column c of matrix m, elements at positions k >= n forced to zero.
    function automatic logic [VW-1:0] col_of(input logic [MW-1:0] m,
                                             input logic [2:0] c,
                                             input logic [2:0] n);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < DIM; k++)
            for (int cc = 0; cc < DIM; cc++)
                if (cc == int'(c) && k < int'(n))
                    v[VW-1-EW*k -: EW] = m[MW-1-EW*(DIM*k+cc) -: EW];
        return v;
    endfunction

    // Index stepping: row-major walk over the N x N result.
    always_comb begin
        n_start   = {1'b0, size} + 3'd2;
        last_j    = (j == n_q - 3'd1);
        last_elem = last_j && (i == n_q - 3'd1);
        next_j    = last_j ? 3'd0 : j + 3'd1;
        next_i    = last_j ? i + 3'd1 : i;
        elem_idx  = DIM*int'(i) + int'(j);
    end

    // Control FSM with registered feed vectors, result matrix and flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= 3'd2;
            i     <= '0;
            j     <= '0;
            lin   <= '0;
            col   <= '0;
            mat_c <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= mat_a;
                        b_q   <= mat_b;
                        n_q   <= n_start;
                        i     <= '0;
                        j     <= '0;
                        lin   <= row_of(mat_a, 3'd0, n_start);
                        col   <= col_of(mat_b, 3'd0, n_start);
                        mat_c <= '0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int e = 0; e < DIM*DIM; e++)
                        if (e == elem_idx)
                            mat_c[MW-1-EW*e -: EW] <= ip_prod;
                    ovf <= ovf | ip_ovf;
                    if (last_elem) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i   <= next_i;
                        j   <= next_j;
                        lin <= row_of(a_q, next_i, n_q);
                        col <= col_of(b_q, next_j, n_q);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed bench for matmul_seq with a behavioural
// inner-product unit attached and a queue of expected results.
module tb_matmul_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   size;
    logic [199:0] mat_a;
    logic [199:0] mat_b;
    logic [39:0]  lin;
    logic [39:0]  col;
    logic [7:0]   ip_prod;
    logic         ip_ovf;
    logic [199:0] mat_c;
    logic         ovf;
    logic         busy;
    logic         done;

    typedef struct {
        logic [199:0] c;
        logic         o;
        int           n;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    matmul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .size    (size),
        .mat_a   (mat_a),
        .mat_b   (mat_b),
        .lin     (lin),
        .col     (col),
        .ip_prod (ip_prod),
        .ip_ovf  (ip_ovf),
        .mat_c   (mat_c),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural intProd_M: 5-wide signed dot product, wrapped to 8 bits,
    // overflow when the exact sum does not fit a signed byte.
    int ip_sum;
    always_comb begin
        ip_sum = 0;
        for (int k = 0; k < 5; k++)
            ip_sum += int'($signed(lin[39-8*k -: 8])) * int'($signed(col[39-8*k -: 8]));
        ip_prod = ip_sum[7:0];
        ip_ovf  = (ip_sum > 127) || (ip_sum < -128);
    end

    function automatic logic [199:0] put(input logic [199:0] m, input int r, input int c, input int v);
        logic [31:0] t;
        t = v;
        m[199-8*(5*r+c) -: 8] = t[7:0];
        return m;
    endfunction

    function automatic int get(input logic [199:0] m, input int r, input int c);
        return int'($signed(m[199-8*(5*r+c) -: 8]));
    endfunction

    task automatic computeRef(input logic [199:0] a, input logic [199:0] b, input int n,
                              output logic [199:0] c, output logic o);
        int s;
        c = '0;
        o = 1'b0;
        for (int r = 0; r < n; r++)
            for (int q = 0; q < n; q++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += get(a, r, k) * get(b, k, q);
                c = put(c, r, q, s);
                if (s > 127 || s < -128) o = 1'b1;
            end
    endtask

    task automatic checkOutput(input string tag, input logic [199:0] observed, input logic [199:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse (DUT assumed idle) and queue the expected result.
    task automatic applyStimulus(input logic [1:0] sz, input logic [199:0] a, input logic [199:0] b);
        exp_t e;
        e.n = int'(sz) + 2;
        computeRef(a, b, e.n, e.c, e.o);
        sb.push_back(e);
        size  = sz;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, then check latency, busy duration, result, pulse width.
    task automatic waitResult(input string tag, input int elapsed);
        int   cyc;
        int   busyc;
        bit   got;
        exp_t e;
        cyc   = elapsed;
        busyc = elapsed;
        got   = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) busyc++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checkOutput({tag, "_timeout"}, 200'(done), 200'(1));
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_latency"}, 200'(cyc), 200'(e.n*e.n + 1));
            checkOutput({tag, "_busy_cycles"}, 200'(busyc), 200'(e.n*e.n));
            checkOutput({tag, "_mat_c"}, mat_c, e.c);
            checkOutput({tag, "_ovf"}, 200'(ovf), 200'(e.o));
            @(negedge clk);
            checkOutput({tag, "_done_width"}, 200'(done), 200'(0));
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] sz, input logic [199:0] a, input logic [199:0] b);
        applyStimulus(sz, a, b);
        waitResult(tag, 0);
    endtask

    logic [199:0] a;
    logic [199:0] b;
    logic [199:0] a2;
    logic [199:0] ones;
    int           ndone;
    int           last_t;
    bit           prev_done;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        size  = 2'b00;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mat_c", mat_c, '0);
        checkOutput("reset_lin", 200'(lin), '0);
        checkOutput("reset_col", 200'(col), '0);
        checkOutput("reset_busy", 200'(busy), '0);
        checkOutput("reset_done", 200'(done), '0);
        checkOutput("reset_ovf", 200'(ovf), '0);
        rst = 1'b1;
        @(negedge clk);

        // 2x2 known product.
        a = '0; b = '0;
        a = put(a,0,0,1); a = put(a,0,1,2); a = put(a,1,0,3); a = put(a,1,1,4);
        b = put(b,0,0,5); b = put(b,0,1,6); b = put(b,1,0,7); b = put(b,1,1,8);
        runOp("mm2x2", 2'b00, a, b);
        checkOutput("mm2x2_c00", 200'(get(mat_c,0,0)), 200'(19));
        checkOutput("mm2x2_c11", 200'(get(mat_c,1,1)), 200'(50));

        // 5x5 with directed row/column pairs, other elements random.
        for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) begin
                a = put(a, r, q, int'($urandom_range(0, 6)) - 3);
                b = put(b, r, q, int'($urandom_range(0, 6)) - 3);
            end
        a = put(a,0,0,1); a = put(a,0,1,2); a = put(a,0,2,3); a = put(a,0,3,2); a = put(a,0,4,5);
        for (int k = 0; k < 5; k++) a = put(a, 1, k, -1);
        b = put(b,0,0,2); b = put(b,1,0,3); b = put(b,2,0,2); b = put(b,3,0,1); b = put(b,4,0,1);
        b = put(b,0,1,2); b = put(b,1,1,3); b = put(b,2,1,-2); b = put(b,3,1,1); b = put(b,4,1,-2);
        runOp("mm5x5_dir", 2'b11, a, b);
        checkOutput("mm5x5_c00", 200'(get(mat_c,0,0)), 200'(21));
        checkOutput("mm5x5_c11", 200'(get(mat_c,1,1)), 200'($signed(-8'sd2)));

        // A all 100 with identity, then with all ones (overflow).
        a = '0; b = '0; ones = '0;
        for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) begin
                a    = put(a, r, q, 100);
                ones = put(ones, r, q, 1);
                b    = put(b, r, q, (r == q) ? 1 : 0);
            end
        runOp("mm_ident", 2'b11, a, b);
        checkOutput("mm_ident_ovf0", 200'(ovf), 200'(0));
        runOp("mm_ones", 2'b11, a, ones);
        checkOutput("mm_ones_ovf1", 200'(ovf), 200'(1));

        // 3x3 and 4x4 random operations.
        for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) begin
                a = put(a, r, q, int'($urandom_range(0, 40)) - 20);
                b = put(b, r, q, int'($urandom_range(0, 40)) - 20);
            end
        runOp("mm3x3", 2'b01, a, b);
        runOp("mm4x4", 2'b10, a, b);

        // Second start mid-run with different A is ignored.
        a2 = ~a;
        applyStimulus(2'b11, a, b);
        repeat (2) @(negedge clk);
        mat_a = a2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitResult("ignored_start", 2);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checkOutput("ignored_start_extra_done", 200'(ndone), 200'(0));

        // Reset in the middle of a 5x5 run, then a clean operation.
        applyStimulus(2'b11, a, b);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_mat_c", mat_c, '0);
        checkOutput("midrst_busy", 200'(busy), '0);
        checkOutput("midrst_done", 200'(done), '0);
        checkOutput("midrst_lin", 200'(lin), '0);
        checkOutput("midrst_col", 200'(col), '0);
        rst = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        runOp("after_rst", 2'b11, a, b);

        // Back-to-back 3x3 with start held high.
        @(posedge clk);
        #1;
        size  = 2'b01;
        mat_a = a;
        mat_b = b;
        begin
            exp_t e;
            e.n = 3;
            computeRef(a, b, 3, e.c, e.o);
            repeat (3) sb.push_back(e);
        end
        start     = 1'b1;
        ndone     = 0;
        last_t    = -1;
        prev_done = 1'b0;
        for (int t = 1; t <= 34; t++) begin
            @(negedge clk);
            if (done) begin
                exp_t e;
                ndone++;
                checkOutput("b2b_done_width", 200'(prev_done), 200'(0));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("b2b_mat_c", mat_c, e.c);
                end
                if (last_t >= 0)
                    checkOutput("b2b_spacing", 200'(t - last_t), 200'(11));
                else
                    checkOutput("b2b_first_latency", 200'(t), 200'(11));
                last_t = t;
            end
            prev_done = done;
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 200'(ndone), 200'(3));
        repeat (3) @(negedge clk);
        checkOutput("b2b_idle_busy", 200'(busy), 200'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
